// File: rtl/voice_mixer_pkg.sv
// voice_mixer_pkg: sample width, clamp value and FSM state encoding shared by the mixer files
package voice_mixer_pkg;
   localparam int SAMPLE_W = 12;
   localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 12'hFFF;
   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;
endpackage

// File: rtl/mix_sat_adder.sv
// mix_sat_adder: 12-bit unsigned add with carry-out; clamps to SAMPLE_MAX on carry when MIX_SATURATE_EN is defined, wraps otherwise
module mix_sat_adder
   import voice_mixer_pkg::*;
(
   input  logic [SAMPLE_W-1:0] a,
   input  logic [SAMPLE_W-1:0] b,
   output logic [SAMPLE_W-1:0] sum,
   output logic                carry
);
   logic [SAMPLE_W:0] full;
   // 13-bit add; the top bit is the overflow indication either way
   always_comb begin
      full  = {1'b0, a} + {1'b0, b};
      carry = full[SAMPLE_W];
`ifdef MIX_SATURATE_EN
      sum   = carry ? SAMPLE_MAX : full[SAMPLE_W-1:0];
`else
      sum   = full[SAMPLE_W-1:0];
`endif
   end
endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: walks NUM_VOICES voices one per clock into a 12-bit mix per sample tick (MIX_SATURATE_EN selects clamp vs wrap)
module voice_mixer
   import voice_mixer_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int SEL_W      = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_tick,
   output logic [SEL_W-1:0]    voice_sel,
   input  logic [SAMPLE_W-1:0] voice_sample,
   input  logic                voice_en,
   output logic [SAMPLE_W-1:0] mix_out,
   output logic                mix_valid,
   output logic                clip,
   output logic                busy,
   output logic                overrun
);
   localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_VOICES - 1);

   state_t              state;
   logic [SAMPLE_W-1:0] acc;
   logic [SAMPLE_W-1:0] addend;
   logic [SAMPLE_W-1:0] sum;
   logic                carry;
   logic                clip_acc;

   assign addend = voice_en ? voice_sample : '0;
   assign busy   = (state == ACC);

   mix_sat_adder u_add (
      .a     (acc),
      .b     (addend),
      .sum   (sum),
      .carry (carry)
   );

   // frame FSM: IDLE waits for a tick, ACC accumulates one voice per cycle and publishes on the last
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         voice_sel <= '0;
         acc       <= '0;
         clip_acc  <= 1'b0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
         clip      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         mix_valid <= 1'b0;
         overrun   <= 1'b0;
         if (state == IDLE) begin
            if (sample_tick) begin
               state     <= ACC;
               acc       <= '0;
               voice_sel <= '0;
               clip_acc  <= 1'b0;
            end
         end else begin
            overrun  <= sample_tick;
            acc      <= sum;
            clip_acc <= clip_acc | carry;
            if (voice_sel == LAST) begin
               mix_out   <= sum;
               clip      <= clip_acc | carry;
               mix_valid <= 1'b1;
               state     <= IDLE;
               voice_sel <= '0;
            end else begin
               voice_sel <= voice_sel + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: randomized and directed checks of voice_mixer against a whole-frame arithmetic model
module tb_voice_mixer;
   logic        clk = 1'b0;
   logic        rst;
   logic        sample_tick;
   logic [1:0]  voice_sel;
   logic [11:0] voice_sample;
   logic        voice_en;
   logic [11:0] mix_out;
   logic        mix_valid;
   logic        clip;
   logic        busy;
   logic        overrun;

   logic [11:0] smp [4];
   logic        en  [4];
   int          checks = 0;
   int          fails  = 0;

   assign voice_sample = smp[voice_sel];
   assign voice_en     = en[voice_sel];

   always #5 clk = ~clk;

   voice_mixer #(.NUM_VOICES(4), .SEL_W(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_tick  (sample_tick),
      .voice_sel    (voice_sel),
      .voice_sample (voice_sample),
      .voice_en     (voice_en),
      .mix_out      (mix_out),
      .mix_valid    (mix_valid),
      .clip         (clip),
      .busy         (busy),
      .overrun      (overrun)
   );

   // whole-frame model: total of enabled samples, then clamp or wrap to 12 bits
   task automatic model(output logic [11:0] m, output logic c);
      int t = 0;
      for (int i = 0; i < 4; i++) t += en[i] ? int'(smp[i]) : 0;
      c = (t > 4095);
`ifdef MIX_SATURATE_EN
      m = c ? 12'hFFF : 12'(t);
`else
      m = 12'(t % 4096);
`endif
   endtask

   task automatic set_voices(input int s0, s1, s2, s3, input logic e0, e1, e2, e3);
      smp[0] = 12'(s0); smp[1] = 12'(s1); smp[2] = 12'(s2); smp[3] = 12'(s3);
      en[0] = e0; en[1] = e1; en[2] = e2; en[3] = e3;
   endtask

   // one frame with timing checks; b2b=1 raises the tick in the current (mix_valid) cycle
   task automatic do_frame(input bit b2b, input string name);
      logic [11:0] em;
      logic        ec;
      if (!b2b) @(negedge clk);
      sample_tick = 1'b1;
      @(posedge clk); #1;
      sample_tick = 1'b0;
      model(em, ec);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (busy !== 1'b1 || mix_valid !== 1'b0 || voice_sel !== 2'(k) || overrun !== 1'b0) begin
            fails++;
            $display("FAIL %s acc cycle %0d: busy=%b mix_valid=%b sel=%0d overrun=%b required busy=1 mix_valid=0 sel=%0d overrun=0",
                     name, k, busy, mix_valid, voice_sel, overrun, k);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (mix_valid !== 1'b1 || busy !== 1'b0 || mix_out !== em || clip !== ec || voice_sel !== 2'd0) begin
         fails++;
         $display("FAIL %s result: mix_valid=%b busy=%b mix_out=%0d clip=%b sel=%0d required mix_valid=1 busy=0 mix_out=%0d clip=%b sel=0",
                  name, mix_valid, busy, mix_out, clip, voice_sel, em, ec);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; sample_tick = 1'b0;
      set_voices(0, 0, 0, 0, 1, 1, 1, 1);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (voice_sel !== 2'd0 || mix_out !== 12'd0 || mix_valid !== 1'b0 || clip !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL reset: sel=%0d mix_out=%0d mix_valid=%b clip=%b busy=%b overrun=%b required all 0",
                  voice_sel, mix_out, mix_valid, clip, busy, overrun);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic;
      set_voices(100, 200, 300, 400, 1, 1, 1, 1);
      do_frame(0, "basic");
      checks++;
      if (mix_out !== 12'd1000) begin
         fails++;
         $display("FAIL basic value: mix_out=%0d required 1000", mix_out);
      end
      @(posedge clk); #1;
      checks++;
      if (mix_valid !== 1'b0 || mix_out !== 12'd1000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL basic hold: mix_valid=%b mix_out=%0d busy=%b required 0 1000 0", mix_valid, mix_out, busy);
      end
   endtask

   task automatic test_overflow;
      set_voices(4000, 100, 0, 0, 1, 1, 1, 1);
      do_frame(0, "overflow");
      checks++;
`ifdef MIX_SATURATE_EN
      if (mix_out !== 12'd4095 || clip !== 1'b1) begin
         fails++;
         $display("FAIL overflow value: mix_out=%0d clip=%b required 4095 1", mix_out, clip);
      end
`else
      if (mix_out !== 12'd4 || clip !== 1'b1) begin
         fails++;
         $display("FAIL overflow value: mix_out=%0d clip=%b required 4 1", mix_out, clip);
      end
`endif
      set_voices(4095, 4095, 4095, 4095, 1, 1, 1, 1);
      do_frame(0, "overflow_all_max");
   endtask

   task automatic test_gating;
      set_voices(10, 2000, 10, 10, 1, 0, 1, 1);
      do_frame(0, "gating");
      checks++;
      if (mix_out !== 12'd30 || clip !== 1'b0) begin
         fails++;
         $display("FAIL gating value: mix_out=%0d clip=%b required 30 0", mix_out, clip);
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 4; i++) begin
            smp[i] = 12'($urandom_range(0, 4095));
            en[i]  = 1'($urandom_range(0, 1));
         end
         if (n % 3 == 0) for (int i = 0; i < 4; i++) smp[i] = 12'($urandom_range(0, 900));
         do_frame(n % 4 == 1, "random");
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_overrun;
      int extra = 0;
      set_voices(100, 200, 300, 400, 1, 1, 1, 1);
      @(negedge clk); sample_tick = 1'b1;
      @(posedge clk); #1; sample_tick = 1'b0;
      @(posedge clk); #1; sample_tick = 1'b1;
      @(posedge clk); #1; sample_tick = 1'b0;
      checks++;
      if (overrun !== 1'b1 || busy !== 1'b1 || voice_sel !== 2'd2) begin
         fails++;
         $display("FAIL overrun pulse: overrun=%b busy=%b sel=%0d required 1 1 2", overrun, busy, voice_sel);
      end
      @(posedge clk); #1;
      checks++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun width: overrun=%b required 0", overrun);
      end
      @(posedge clk); #1;
      checks++;
      if (mix_valid !== 1'b1 || mix_out !== 12'd1000 || clip !== 1'b0) begin
         fails++;
         $display("FAIL overrun frame: mix_valid=%b mix_out=%0d clip=%b required 1 1000 0", mix_valid, mix_out, clip);
      end
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (mix_valid === 1'b1 || busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         fails++;
         $display("FAIL overrun extra frame: active cycles=%0d required 0", extra);
      end
   endtask

   task automatic test_back_to_back;
      set_voices(1, 2, 3, 4, 1, 1, 1, 1);
      do_frame(0, "b2b_first");
      set_voices(50, 60, 70, 80, 1, 1, 0, 1);
      do_frame(1, "b2b_second");
      checks++;
      if (mix_out !== 12'd190) begin
         fails++;
         $display("FAIL b2b value: mix_out=%0d required 190", mix_out);
      end
   endtask

   task automatic test_mid_reset;
      int extra = 0;
      set_voices(500, 500, 500, 500, 1, 1, 1, 1);
      @(negedge clk); sample_tick = 1'b1;
      @(posedge clk); #1; sample_tick = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (voice_sel !== 2'd0 || mix_out !== 12'd0 || mix_valid !== 1'b0 || clip !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL mid reset: sel=%0d mix_out=%0d mix_valid=%b clip=%b busy=%b overrun=%b required all 0",
                  voice_sel, mix_out, mix_valid, clip, busy, overrun);
      end
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (mix_valid === 1'b1 || busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         fails++;
         $display("FAIL mid reset aborted frame: active cycles=%0d required 0", extra);
      end
      set_voices(7, 8, 9, 10, 1, 1, 1, 1);
      do_frame(0, "after_reset");
   endtask

   initial begin
      test_reset;
      test_basic;
      test_overflow;
      test_gating;
      test_overrun;
      test_back_to_back;
      test_random;
      test_mid_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
